// File: rtl/mul_seq_pkg.sv
// rtl/mul_seq_pkg.sv - shared types and constants for the nibble-serial multiplier
package mul_seq_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam int NIB_W = 4;
    // Operands up to 16 bits give at most four nibbles per operand.
    localparam int IDX_W = 2;
    localparam int PASS_W = 5;

    function automatic int pass_count(input int op_w);
        return (op_w / NIB_W) * (op_w / NIB_W);
    endfunction

endpackage

// File: rtl/mul4x4_array.sv
// rtl/mul4x4_array.sv - combinational unsigned 4x4 array multiplier
module mul4x4_array (
    input  logic [3:0] a,
    input  logic [3:0] b,
    output logic [7:0] p
);

    logic [4:0] row [4];
    logic       carry;
    logic       x;
    logic       y;

    // Each row adds the next AND partial product to the previous row shifted
    // right by one; the bit shifted out is a settled product bit.
    always_comb begin
        carry = 1'b0;
        x     = 1'b0;
        y     = 1'b0;
        for (int r = 0; r < 4; r++) begin
            row[r] = '0;
        end
        row[0] = {1'b0, a & {4{b[0]}}};
        for (int r = 1; r < 4; r++) begin
            carry = 1'b0;
            for (int k = 0; k < 4; k++) begin
                x = a[k] & b[r];
                y = row[r-1][k+1];
                row[r][k] = x ^ y ^ carry;
                carry = (x & y) | (carry & (x ^ y));
            end
            row[r][4] = carry;
        end
        p = {row[3], row[2][0], row[1][0], row[0][0]};
    end

endmodule

// File: rtl/mul8_nibble_sequencer.sv
// rtl/mul8_nibble_sequencer.sv - OP_W x OP_W multiplier reusing one 4x4 core per cycle
module mul8_nibble_sequencer
    import mul_seq_pkg::*;
#(
    parameter int OP_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [OP_W-1:0]   in_a,
    input  logic [OP_W-1:0]   in_b,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [2*OP_W-1:0] out_prod,
    output logic              busy
);

    localparam int NIBS   = OP_W / NIB_W;
    localparam int N_PASS = pass_count(OP_W);
    localparam int PW     = 2 * OP_W;
    localparam logic [PASS_W-1:0] LAST_PASS = PASS_W'(N_PASS - 1);
    localparam logic [IDX_W-1:0]  LAST_IDX  = IDX_W'(NIBS - 1);

    state_t state;
    state_t next_state;

    logic [OP_W-1:0]   a_reg;
    logic [OP_W-1:0]   b_reg;
    logic [PW-1:0]     acc;
    logic [IDX_W-1:0]  i_idx;
    logic [IDX_W-1:0]  j_idx;
    logic [PASS_W-1:0] pass;
    logic              ready_q;

    logic [OP_W-1:0]   a_shift;
    logic [OP_W-1:0]   b_shift;
    logic [3:0]        a_nib;
    logic [3:0]        b_nib;
    logic [7:0]        pp;
    logic [2:0]        ij_sum;
    logic [PW-1:0]     pp_ext;
    logic              accept;
    logic              last_pass;

    assign a_shift   = a_reg >> {i_idx, 2'b00};
    assign b_shift   = b_reg >> {j_idx, 2'b00};
    assign a_nib     = a_shift[3:0];
    assign b_nib     = b_shift[3:0];
    assign ij_sum    = 3'(i_idx) + 3'(j_idx);
    assign pp_ext    = PW'(pp) << {ij_sum, 2'b00};
    assign accept    = (state == S_IDLE) && ready_q && in_valid;
    assign last_pass = (pass == LAST_PASS);

    mul4x4_array u_core (
        .a (a_nib),
        .b (b_nib),
        .p (pp)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            S_IDLE: if (accept) next_state = S_RUN;
            S_RUN:  if (last_pass) next_state = S_DONE;
            S_DONE: if (out_ready) next_state = S_IDLE;
            default: next_state = S_IDLE;
        endcase
    end

    // in_ready is registered so it stays low for the whole reset cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            ready_q <= 1'b0;
            a_reg   <= '0;
            b_reg   <= '0;
            acc     <= '0;
            i_idx   <= '0;
            j_idx   <= '0;
            pass    <= '0;
        end else begin
            ready_q <= (next_state == S_IDLE);
            if (accept) begin
                a_reg <= in_a;
                b_reg <= in_b;
                acc   <= '0;
                i_idx <= '0;
                j_idx <= '0;
                pass  <= '0;
            end else if (state == S_RUN) begin
                acc  <= acc + pp_ext;
                pass <= pass + 1'b1;
                if (i_idx == LAST_IDX) begin
                    i_idx <= '0;
                    j_idx <= j_idx + 1'b1;
                end else begin
                    i_idx <= i_idx + 1'b1;
                end
            end
        end
    end

    assign in_ready  = ready_q;
    assign out_valid = (state == S_DONE);
    assign busy      = (state != S_IDLE);
    assign out_prod  = acc;

endmodule

// File: tb/tb_mul8_nibble_sequencer.sv
// tb/tb_mul8_nibble_sequencer.sv - randomized and directed bench with a cycle-level reference model
module tb_mul8_nibble_sequencer;

    localparam int NP = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [7:0]  in_a = '0;
    logic [7:0]  in_b = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [15:0] out_prod;
    logic        busy;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int ready_mode = 0;

    logic        m_active = 1'b0;
    logic        m_rstb = 1'b1;
    int          m_tacc = 0;
    logic [15:0] m_cur = '0;
    logic [15:0] m_hold = '0;
    logic        exp_valid;
    logic        exp_ready;
    int          busy_cnt = 0;
    int          first_valid = -1;
    int          acc_edges[$];
    logic [15:0] res_log[$];

    mul8_nibble_sequencer #(.OP_W(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_prod  (out_prod),
        .busy      (busy)
    );

    initial forever #5 clk = ~clk;

    always @(posedge clk) cyc++;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h (cycle %0d)", nm, act, req, cyc);
        end
    endtask

    // Reference model: request accepted at edge T makes the result visible
    // from edge T+NP until the sink takes it; idle output holds the last product.
    always @(negedge clk) begin
        if (cyc > 0) begin
            exp_valid = m_active && (cyc >= m_tacc + NP);
            exp_ready = !m_active && !m_rstb;
            chk("out_valid", {31'd0, out_valid}, {31'd0, exp_valid});
            chk("busy", {31'd0, busy}, {31'd0, m_active});
            chk("in_ready", {31'd0, in_ready}, {31'd0, exp_ready});
            if (!m_active) chk("out_prod_hold", {16'd0, out_prod}, {16'd0, m_hold});
            else if (exp_valid) chk("out_prod", {16'd0, out_prod}, {16'd0, m_cur});
            if (busy) busy_cnt++;
            if (out_valid && first_valid < 0) first_valid = cyc;
            if (rst) begin
                m_active = 1'b0;
                m_hold   = '0;
            end else if (exp_ready && in_valid) begin
                m_active    = 1'b1;
                m_tacc      = cyc + 1;
                m_cur       = 16'(int'(in_a) * int'(in_b));
                busy_cnt    = 0;
                first_valid = -1;
                acc_edges.push_back(cyc + 1);
            end else if (exp_valid && out_ready) begin
                m_active = 1'b0;
                m_hold   = m_cur;
                res_log.push_back(out_prod);
            end
            m_rstb = rst;
        end
    end

    initial forever begin
        @(posedge clk);
        #1;
        case (ready_mode)
            0: out_ready = 1'b1;
            1: out_ready = ($urandom_range(0, 2) != 0);
            default: out_ready = 1'b0;
        endcase
    end

    task automatic send(input logic [7:0] a, input logic [7:0] b);
        int start;
        bit ok;
        start = acc_edges.size();
        ok = 0;
        in_a = a;
        in_b = b;
        in_valid = 1'b1;
        for (int k = 0; k < 100; k++) begin
            @(posedge clk);
            #1;
            if (acc_edges.size() != start) begin
                ok = 1;
                break;
            end
        end
        in_valid = 1'b0;
        in_a = 8'($urandom);
        in_b = 8'($urandom);
        if (!ok) chk("accept_timeout", 32'd0, 32'd1);
    endtask

    task automatic wait_result(output logic [15:0] r);
        int start;
        bit ok;
        start = res_log.size();
        ok = 0;
        r = '0;
        for (int k = 0; k < 300; k++) begin
            @(posedge clk);
            #1;
            if (res_log.size() != start) begin
                ok = 1;
                break;
            end
        end
        if (ok) r = res_log[res_log.size() - 1];
        else chk("result_timeout", 32'd0, 32'd1);
    endtask

    task automatic op_check(input string nm, input logic [7:0] a, input logic [7:0] b,
                            input logic [15:0] req);
        logic [15:0] r;
        send(a, b);
        wait_result(r);
        chk(nm, {16'd0, r}, {16'd0, req});
    endtask

    initial begin
        logic [15:0] r;
        int n0;
        bit ok;

        ready_mode = 0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk);
        #1;

        send(8'h12, 8'h34);
        wait_result(r);
        chk("res_12x34", {16'd0, r}, 32'h03A8);
        chk("latency", first_valid - acc_edges[acc_edges.size() - 1], NP);
        chk("busy_cycles", busy_cnt, NP + 1);

        op_check("res_FFxFF", 8'hFF, 8'hFF, 16'hFE01);
        op_check("res_00xA5", 8'h00, 8'hA5, 16'h0000);
        op_check("res_01x80", 8'h01, 8'h80, 16'h0080);

        ready_mode = 2;
        @(posedge clk);
        #1;
        send(8'hA5, 8'h3C);
        ok = 0;
        for (int k = 0; k < 50; k++) begin
            @(negedge clk);
            if (out_valid) begin
                ok = 1;
                break;
            end
        end
        if (!ok) chk("stall_valid_timeout", 32'd0, 32'd1);
        for (int k = 0; k < 7; k++) begin
            @(posedge clk);
            #1;
            in_a = 8'($urandom);
            in_b = 8'($urandom);
            @(negedge clk);
            chk("stall_prod", {16'd0, out_prod}, 32'h26AC);
            chk("stall_in_ready", {31'd0, in_ready}, 32'd0);
        end
        ready_mode = 0;
        wait_result(r);
        chk("res_A5x3C", {16'd0, r}, 32'h26AC);

        n0 = res_log.size();
        @(posedge clk);
        #1;
        in_a = 8'h0F;
        in_b = 8'h0F;
        in_valid = 1'b1;
        begin
            int s;
            s = acc_edges.size();
            for (int k = 0; k < 50 && acc_edges.size() == s; k++) begin
                @(posedge clk);
                #1;
            end
            in_a = 8'hF0;
            in_b = 8'hF0;
            for (int k = 0; k < 50 && acc_edges.size() == s + 1; k++) begin
                @(posedge clk);
                #1;
            end
            in_valid = 1'b0;
            for (int k = 0; k < 50 && res_log.size() < n0 + 2; k++) begin
                @(posedge clk);
                #1;
            end
            if (res_log.size() >= n0 + 2 && acc_edges.size() >= s + 2) begin
                chk("b2b_res0", {16'd0, res_log[n0]}, 32'h00E1);
                chk("b2b_res1", {16'd0, res_log[n0 + 1]}, 32'hE100);
                chk("b2b_spacing", acc_edges[s + 1] - acc_edges[s], NP + 2);
            end else begin
                chk("b2b_timeout", 32'd0, 32'd1);
            end
        end

        n0 = res_log.size();
        send(8'hFF, 8'hFF);
        @(posedge clk);
        @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_in_ready_low", {31'd0, in_ready}, 32'd0);
        chk("rst_prod_zero", {16'd0, out_prod}, 32'd0);
        @(negedge clk);
        chk("rst_in_ready_high", {31'd0, in_ready}, 32'd1);
        repeat (8) @(posedge clk);
        #1;
        chk("rst_no_result", res_log.size(), n0);
        op_check("res_03x05", 8'h03, 8'h05, 16'h000F);

        ready_mode = 1;
        n0 = res_log.size();
        for (int t = 0; t < 2000; t++) begin
            logic [7:0] a;
            logic [7:0] b;
            a = 8'($urandom);
            b = 8'($urandom);
            if ($urandom_range(0, 15) == 0) a = 8'hFF;
            if ($urandom_range(0, 15) == 0) b = 8'h00;
            send(a, b);
            wait_result(r);
            repeat ($urandom_range(0, 2)) @(posedge clk);
            #1;
        end
        chk("sweep_count", res_log.size() - n0, 2000);

        ready_mode = 0;
        repeat (3) @(posedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
